// File: rtl/regfile_access_seq.sv
// Shared-bus access sequencer for the 32x32 register file: optional writeback of rd,
// then fetch of up to two source operands, returned on a valid/ready response.
module regfile_access_seq #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_rd_i,
  input  logic              cmd_rd_en_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [ADDR_W-1:0] cmd_rs1_i,
  input  logic [ADDR_W-1:0] cmd_rs2_i,
  input  logic [1:0]        cmd_nsrc_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_a_o,
  output logic [DATA_W-1:0] rsp_b_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic              rf_wrt_o,
  output logic              rf_en_o,
  output logic              bus_drv_o,
  output logic [DATA_W-1:0] bus_out_o,
  input  logic [DATA_W-1:0] bus_in_i,
  output logic [CNT_W-1:0]  cmd_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_A,
    S_WAIT_A,
    S_RD_B,
    S_WAIT_B,
    S_RESP
  } state_e;

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < NUM_REGS_C;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;
  logic                do_a_q, do_a_d;
  logic                do_b_q, do_b_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0]   rsp_b_q, rsp_b_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                rf_wrt_q, rf_wrt_d;
  logic                rf_en_q, rf_en_d;
  logic                bus_drv_q, bus_drv_d;
  logic [DATA_W-1:0]   bus_out_q, bus_out_d;
  logic [CNT_W-1:0]    cmd_count_q, cmd_count_d;

  logic accept;
  logic acc_has_a, acc_has_b;
  logic acc_wr, acc_a, acc_b, acc_err;

  assign accept    = cmd_valid_i & cmd_ready_q;
  assign acc_has_a = (cmd_nsrc_i != 2'd0);
  assign acc_has_b = cmd_nsrc_i[1];  // nsrc of 3 behaves as 2

  assign acc_wr  = cmd_rd_en_i & (cmd_rd_i != '0) & in_range(cmd_rd_i);
  assign acc_a   = acc_has_a & (cmd_rs1_i != '0) & in_range(cmd_rs1_i);
  assign acc_b   = acc_has_b & (cmd_rs2_i != '0) & in_range(cmd_rs2_i);
  assign acc_err = (cmd_rd_en_i & ~in_range(cmd_rd_i))
                 | (acc_has_a   & ~in_range(cmd_rs1_i))
                 | (acc_has_b   & ~in_range(cmd_rs2_i));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    do_a_d      = do_a_q;
    do_b_d      = do_b_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_err_d   = rsp_err_q;
    cmd_count_d = cmd_count_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rs1_d     = cmd_rs1_i;
          rs2_d     = cmd_rs2_i;
          do_a_d    = acc_a;
          do_b_d    = acc_b;
          rsp_a_d   = '0;
          rsp_b_d   = '0;
          rsp_err_d = acc_err;
          if (acc_wr)      state_d = S_WR;
          else if (acc_a)  state_d = S_RD_A;
          else if (acc_b)  state_d = S_RD_B;
          else             state_d = S_RESP;
        end
      end
      S_WR: begin
        if (do_a_q)      state_d = S_RD_A;
        else if (do_b_q) state_d = S_RD_B;
        else             state_d = S_RESP;
      end
      S_RD_A:   state_d = S_WAIT_A;
      S_WAIT_A: begin
        rsp_a_d = bus_in_i;
        state_d = do_b_q ? S_RD_B : S_RESP;
      end
      S_RD_B:   state_d = S_WAIT_B;
      S_WAIT_B: begin
        rsp_b_d = bus_in_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          cmd_count_d = cmd_count_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they line up with the phase.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rf_wrt_d    = (state_d == S_WR);
    bus_drv_d   = (state_d == S_WR);
    rf_en_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    bus_out_d   = bus_out_q;
    case (state_d)
      S_WR: begin
        // WR is only ever entered on the accept edge, so the live command fields apply.
        rf_en_d   = 1'b1;
        rf_addr_d = cmd_rd_i;
        bus_out_d = cmd_wdata_i;
      end
      S_RD_A, S_WAIT_A: begin
        rf_en_d   = 1'b1;
        rf_addr_d = rs1_d;
      end
      S_RD_B, S_WAIT_B: begin
        rf_en_d   = 1'b1;
        rf_addr_d = rs2_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      do_a_q      <= 1'b0;
      do_b_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_err_q   <= 1'b0;
      rf_addr_q   <= '0;
      rf_wrt_q    <= 1'b0;
      rf_en_q     <= 1'b0;
      bus_drv_q   <= 1'b0;
      bus_out_q   <= '0;
      cmd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      do_a_q      <= do_a_d;
      do_b_q      <= do_b_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_err_q   <= rsp_err_d;
      rf_addr_q   <= rf_addr_d;
      rf_wrt_q    <= rf_wrt_d;
      rf_en_q     <= rf_en_d;
      bus_drv_q   <= bus_drv_d;
      bus_out_q   <= bus_out_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_a_o     = rsp_a_q;
  assign rsp_b_o     = rsp_b_q;
  assign rsp_err_o   = rsp_err_q;
  assign rf_addr_o   = rf_addr_q;
  assign rf_wrt_o    = rf_wrt_q;
  assign rf_en_o     = rf_en_q;
  assign bus_drv_o   = bus_drv_q;
  assign bus_out_o   = bus_out_q;
  assign cmd_count_o = cmd_count_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed bench for regfile_access_seq with a small behavioural register file on the bus.
module tb_regfile_access_seq;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_rd;
  logic              cmd_rd_en;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [1:0]        cmd_nsrc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_a;
  logic [DATA_W-1:0] rsp_b;
  logic              rsp_err;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_wrt;
  logic              rf_en;
  logic              bus_drv;
  logic [DATA_W-1:0] bus_out;
  logic [DATA_W-1:0] bus_in;
  logic [CNT_W-1:0]  cmd_count;

  int errors = 0;
  int checks = 0;

  logic              preload;
  logic [DATA_W-1:0] rf_mem [32];

  regfile_access_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(32), .CNT_W(CNT_W)
  ) dut (
    .clock_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_rd_i(cmd_rd), .cmd_rd_en_i(cmd_rd_en), .cmd_wdata_i(cmd_wdata),
    .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_nsrc_i(cmd_nsrc),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_a_o(rsp_a), .rsp_b_o(rsp_b), .rsp_err_o(rsp_err),
    .rf_addr_o(rf_addr), .rf_wrt_o(rf_wrt), .rf_en_o(rf_en),
    .bus_drv_o(bus_drv), .bus_out_o(bus_out), .bus_in_i(bus_in),
    .cmd_count_o(cmd_count)
  );

  always #5 clk = ~clk;

  // Register file on the shared bus: commits on RegWrt, drives read data otherwise.
  always @(posedge clk) begin
    if (preload) rf_mem[3] <= 32'h0000_0033;
    else if (rf_en && rf_wrt && bus_drv) rf_mem[rf_addr[4:0]] <= bus_out;
  end
  assign bus_in = (rf_en && !rf_wrt) ? rf_mem[rf_addr[4:0]] : (bus_drv ? bus_out : '0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command; returns #1 after the accept edge.
  task automatic issue(input logic [ADDR_W-1:0] rd, input logic rd_en, input logic [DATA_W-1:0] wd,
                       input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2, input logic [1:0] nsrc);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_rd_en = rd_en;
    cmd_wdata = wd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_nsrc  = nsrc;
    step();
    cmd_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until rsp_valid rises (bounded).
  task automatic wait_rsp(input int exp_lat, input string tag);
    int n = 1;
    while (rsp_valid !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_cmd(input string tag,
                         input logic [ADDR_W-1:0] rd, input logic rd_en, input logic [DATA_W-1:0] wd,
                         input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2, input logic [1:0] nsrc,
                         input int exp_lat, input logic [DATA_W-1:0] exp_a, input logic [DATA_W-1:0] exp_b,
                         input logic exp_err, input logic [CNT_W-1:0] exp_count);
    issue(rd, rd_en, wd, rs1, rs2, nsrc);
    wait_rsp(exp_lat, tag);
    check({tag, "_a"}, rsp_a, exp_a);
    check({tag, "_b"}, rsp_b, exp_b);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_ready_busy"}, cmd_ready, 0);
    step();
    check({tag, "_count"}, cmd_count, exp_count);
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    preload   = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd    = '0;
    cmd_rd_en = 1'b0;
    cmd_wdata = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_nsrc  = '0;
    rsp_ready = 1'b1;
    step();
    step();

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_a", rsp_a, 0);
    check("rst_rsp_b", rsp_b, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_en", {rf_en, rf_wrt, bus_drv}, 0);
    check("rst_bus_out", bus_out, 0);
    check("rst_count", cmd_count, 0);
    reset   = 1'b0;
    preload = 1'b0;
    step();

    // Writeback only: one WR cycle, response two cycles after accept.
    issue(6'd5, 1'b1, 32'hA5A5_0005, 6'd0, 6'd0, 2'd0);
    check("t1_wr_addr", rf_addr, 5);
    check("t1_wr_ctl", {rf_en, rf_wrt, bus_drv}, 3'b111);
    check("t1_wr_data", bus_out, 32'hA5A5_0005);
    check("t1_wr_no_valid", rsp_valid, 0);
    wait_rsp(2, "t1");
    check("t1_ctl_idle", {rf_en, rf_wrt, bus_drv}, 0);
    check("t1_a", rsp_a, 0);
    check("t1_b", rsp_b, 0);
    check("t1_err", rsp_err, 0);
    step();
    check("t1_count", cmd_count, 1);
    check("t1_rf_written", rf_mem[5], 32'hA5A5_0005);

    // Full command with write-before-read on rs1 == rd.
    run_cmd("t2", 6'd7, 1'b1, 32'h0000_1234, 6'd7, 6'd3, 2'd2, 6, 32'h1234, 32'h33, 1'b0, 4'd2);

    // r0 and out-of-range sources: no bus cycles, error flagged.
    issue(6'd0, 1'b0, 32'h0, 6'd0, 6'd32, 2'd2);
    check("t3_no_bus", {rf_en, rf_wrt, bus_drv}, 0);
    wait_rsp(1, "t3");
    check("t3_a", rsp_a, 0);
    check("t3_b", rsp_b, 0);
    check("t3_err", rsp_err, 1);
    step();
    check("t3_count", cmd_count, 3);

    // rd=0 suppresses the write; nsrc=3 fetches both operands.
    run_cmd("rd0_nsrc3", 6'd0, 1'b1, 32'hDEAD_BEEF, 6'd3, 6'd5, 2'd3, 5, 32'h33, 32'hA5A5_0005, 1'b0, 4'd4);
    // Out-of-range rd: error, no write cycle.
    run_cmd("rd40", 6'd40, 1'b1, 32'hDEAD_BEEF, 6'd0, 6'd0, 2'd0, 1, 32'h0, 32'h0, 1'b1, 4'd5);

    // Consumer back-pressure: response held stable while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(6'd0, 1'b0, 32'h0, 6'd3, 6'd9, 2'd1);
    wait_rsp(3, "t4");
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_a", rsp_a, 32'h33);
      check("t4_hold_b", rsp_b, 0);
      check("t4_hold_busy", cmd_ready, 0);
      check("t4_hold_no_rf", rf_en, 0);
      check("t4_hold_count", cmd_count, 5);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("t4_count", cmd_count, 6);
    check("t4_released", rsp_valid, 0);
    check("t4_a_kept", rsp_a, 32'h33);

    // Reset during WAIT_A aborts the command.
    issue(6'd0, 1'b0, 32'h0, 6'd3, 6'd7, 2'd2);
    step();
    check("t5_in_wait_a", {rf_en, rf_wrt}, 2'b10);
    check("t5_addr_wait_a", rf_addr, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_ready", cmd_ready, 1);
    check("t5_rst_valid", rsp_valid, 0);
    check("t5_rst_addr", rf_addr, 0);
    check("t5_rst_ctl", {rf_en, rf_wrt, bus_drv}, 0);
    check("t5_rst_count", cmd_count, 0);
    step();
    check("t5_no_rsp", rsp_valid, 0);
    run_cmd("t5_after", 6'd0, 1'b0, 32'h0, 6'd7, 6'd5, 2'd2, 5, 32'h1234, 32'hA5A5_0005, 1'b0, 4'd1);

    // Counter wrap with a 4-bit counter: 17 empty commands from zero.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_start", cmd_count, 0);
    for (int i = 1; i <= 17; i++) begin
      run_cmd("t6", 6'd0, 1'b0, 32'h0, 6'd0, 6'd0, 2'd0, 1, 32'h0, 32'h0, 1'b0, 4'(i % 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
